// File: rtl/sha256_kw_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_kw_scheduler_if
// Brief    : Block-load and round-stream bundle for the SHA-256 round sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_kw_scheduler_if;
    logic         start;
    logic [511:0] blk_data;
    logic         busy;
    logic         round_valid;
    logic         round_ready;
    logic [5:0]   round_n;
    logic [31:0]  k_out;
    logic [31:0]  w_out;
    logic         last;
    logic         done;

    // master: block loader / compression datapath; slave: the sequencer
    modport master (
        output start, blk_data, round_ready,
        input  busy, round_valid, round_n, k_out, w_out, last, done
    );
    modport slave (
        input  start, blk_data, round_ready,
        output busy, round_valid, round_n, k_out, w_out, last, done
    );
endinterface
`default_nettype wire

// File: rtl/sha256_kw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sha256_kw_scheduler
// Brief    : Issues SHA-256 rounds (t, K_t, W_t) from a 16-word sliding window.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_kw_scheduler #(
    parameter int ROUNDS = 64,
    parameter bit BSWAP  = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    sha256_kw_scheduler_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_last_round = 6'(ROUNDS - 1);

    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t       r_state;
    state_t       w_state_next;
    logic [31:0]  r_win [16];
    logic [31:0]  w_load [16];
    logic [5:0]   r_round;
    logic [31:0]  r_k;
    logic         w_accept;
    logic         w_final;
    logic [31:0]  w_new;

    generate
        for (genvar i = 0; i < 16; i++) begin : g_load
            logic [31:0] w_m;
            assign w_m = bus.blk_data[511 - 32*i -: 32];
            if (BSWAP) begin : g_swap
                assign w_load[i] = {w_m[7:0], w_m[15:8], w_m[23:16], w_m[31:24]};
            end else begin : g_pass
                assign w_load[i] = w_m;
            end
        end
    endgenerate

    always_comb begin
        w_accept     = (r_state == S_RUN) && bus.round_ready;
        w_final      = w_accept && (r_round == c_last_round);
        w_new        = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_final)   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The final accept leaves round/K/window untouched so they hold after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round <= 6'd0;
            r_k     <= 32'd0;
            for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_round <= 6'd0;
            r_k     <= c_k[0];
            for (int i = 0; i < 16; i++) r_win[i] <= w_load[i];
        end else if (w_accept && !w_final) begin
            r_round <= r_round + 6'd1;
            r_k     <= c_k[r_round + 6'd1];
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_new;
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.round_valid = (r_state == S_RUN);
    assign bus.round_n     = r_round;
    assign bus.k_out       = r_k;
    assign bus.w_out       = r_win[0];
    assign bus.last        = (r_state == S_RUN) && (r_round == c_last_round);
    assign bus.done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sha256_kw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_kw_scheduler
// Brief    : Scoreboard bench for the SHA-256 round sequencer (64/plain and 16/bswap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_kw_scheduler;

    typedef struct {
        logic [5:0]  n;
        logic [31:0] k;
        logic [31:0] w;
        logic        last;
    } exp_t;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   n_acc;
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t last_e;
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];

    sha256_kw_scheduler_if b1();
    sha256_kw_scheduler_if b2();

    sha256_kw_scheduler #(.ROUNDS(64), .BSWAP(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    sha256_kw_scheduler #(.ROUNDS(16), .BSWAP(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Full software message-schedule expansion, queued per round.
    task automatic push_expected(input int sel, input logic [511:0] blk);
        logic [31:0] w [64];
        int rounds;
        exp_t e;
        rounds = (sel == 1) ? 64 : 16;
        for (int t = 0; t < 16; t++) begin
            w[t] = blk[511 - 32*t -: 32];
            if (sel == 2) w[t] = bswap(w[t]);
        end
        for (int t = 16; t < 64; t++)
            w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        for (int t = 0; t < rounds; t++) begin
            e.n    = t[5:0];
            e.k    = KT[t];
            e.w    = w[t];
            e.last = (t == rounds - 1);
            if (sel == 1) sb1.push_back(e);
            else          sb2.push_back(e);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic do_start(input int sel, input logic [511:0] blk);
        if (sel == 1) begin
            b1.blk_data = blk; b1.start = 1'b1; b1.round_ready = 1'b0;
        end else begin
            b2.blk_data = blk; b2.start = 1'b1; b2.round_ready = 1'b0;
        end
        push_expected(sel, blk);
        @(negedge clk);
        b1.start = 1'b0;
        b2.start = 1'b0;
        n_cmp++;
        if (sel == 1) begin
            if (b1.round_valid !== 1'b1 || b1.round_n !== 6'd0 || b1.k_out !== KT[0]) begin
                n_fail++;
                $display("FAIL start_latency1: got valid=%b n=%0d k=%h, want valid=1 n=0 k=%h",
                         b1.round_valid, b1.round_n, b1.k_out, KT[0]);
            end
        end else begin
            if (b2.round_valid !== 1'b1 || b2.round_n !== 6'd0 || b2.k_out !== KT[0]) begin
                n_fail++;
                $display("FAIL start_latency2: got valid=%b n=%0d k=%h, want valid=1 n=0 k=%h",
                         b2.round_valid, b2.round_n, b2.k_out, KT[0]);
            end
        end
    endtask

    // mode 0: ready always 1; mode 1: 3-cycle stall at round 5 then random ready.
    task automatic drain(input int mode, input int pulse_round, input bit check_done);
        int   budget;
        int   stalls;
        bit   rdy;
        bit   fin;
        exp_t e;
        budget = 2000; stalls = 0; fin = 1'b0; n_acc = 0;
        while (!fin) begin
            @(negedge clk);
            budget--;
            if (budget == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL drain_timeout: got %0d rounds left, want 0", sb1.size());
                sb1.delete(); b1.round_ready = 1'b0;
                return;
            end
            b1.start = 1'b0;
            if (pulse_round >= 0 && b1.round_valid === 1'b1 && b1.round_n == pulse_round[5:0]) begin
                b1.start    = 1'b1;
                b1.blk_data = rand_blk();
            end
            n_cmp++;
            if (b1.round_valid !== 1'b1 || sb1.size() == 0) begin
                n_fail++;
                $display("FAIL round_valid: got valid=%b pending=%0d, want valid=1 while rounds pending",
                         b1.round_valid, sb1.size());
                if (sb1.size() == 0) return;
                continue;
            end
            e = sb1[0];
            if (b1.round_n !== e.n || b1.k_out !== e.k || b1.w_out !== e.w || b1.last !== e.last) begin
                n_fail++;
                $display("FAIL round: got n=%0d k=%h w=%h last=%b, want n=%0d k=%h w=%h last=%b",
                         b1.round_n, b1.k_out, b1.w_out, b1.last, e.n, e.k, e.w, e.last);
            end
            rdy = 1'b1;
            if (mode == 1) begin
                if (b1.round_n == 6'd5 && stalls < 3) begin
                    rdy = 1'b0; stalls++;
                end else if (stalls >= 3) begin
                    rdy = ($urandom_range(0, 1) == 1);
                end
            end
            b1.round_ready = rdy;
            if (rdy) begin
                obs_w[e.n] = b1.w_out;
                obs_k[e.n] = b1.k_out;
                last_e     = e;
                void'(sb1.pop_front());
                n_acc++;
                if (e.last) fin = 1'b1;
            end
        end
        if (check_done) begin
            @(negedge clk);
            n_cmp++;
            if (b1.done !== 1'b1 || b1.round_valid !== 1'b0 || b1.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL done_pulse: got done=%b valid=%b busy=%b, want 1 0 1",
                         b1.done, b1.round_valid, b1.busy);
            end
            @(negedge clk);
            n_cmp++;
            if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL done_end: got done=%b busy=%b, want 0 0", b1.done, b1.busy);
            end
            b1.round_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({b1.busy, b1.round_valid, b1.round_n, b1.k_out, b1.w_out, b1.last, b1.done} !== 74'd0
            || b2.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b valid=%b n=%0d k=%h w=%h, want all 0",
                     b1.busy, b1.round_valid, b1.round_n, b1.k_out, b1.w_out);
        end
        rst = 1'b0;
        @(negedge clk);
        do_start(1, rand_blk());
        b1.round_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({b1.busy, b1.round_valid, b1.round_n, b1.k_out, b1.w_out, b1.last, b1.done} !== 74'd0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b valid=%b n=%0d k=%h w=%h, want all 0 before edge",
                     b1.busy, b1.round_valid, b1.round_n, b1.k_out, b1.w_out);
        end
        @(negedge clk);
        rst = 1'b0;
        b1.round_ready = 1'b0;
        sb1.delete();
    endtask

    task automatic test_abc();
        @(negedge clk);
        do_start(1, {32'h61626380, {14{32'h0}}, 32'h00000018});
        drain(0, -1, 1'b1);
        n_cmp++;
        if (obs_w[16] !== 32'h61626380 || obs_w[17] !== 32'h000f0000) begin
            n_fail++;
            $display("FAIL abc_w16_17: got %h %h, want 61626380 000f0000", obs_w[16], obs_w[17]);
        end
        n_cmp++;
        if (obs_k[0] !== 32'h428a2f98 || obs_k[63] !== 32'hc67178f2) begin
            n_fail++;
            $display("FAIL abc_k0_k63: got %h %h, want 428a2f98 c67178f2", obs_k[0], obs_k[63]);
        end
        n_cmp++;
        if (b1.round_n !== last_e.n || b1.w_out !== last_e.w || b1.k_out !== last_e.k) begin
            n_fail++;
            $display("FAIL hold_after_done: got n=%0d k=%h w=%h, want n=%0d k=%h w=%h",
                     b1.round_n, b1.k_out, b1.w_out, last_e.n, last_e.k, last_e.w);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        do_start(1, rand_blk());
        drain(1, -1, 1'b1);
        n_cmp++;
        if (n_acc != 64) begin
            n_fail++;
            $display("FAIL accept_count: got %0d, want 64", n_acc);
        end
    endtask

    task automatic test_start();
        @(negedge clk);
        do_start(1, rand_blk());
        drain(0, 20, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (b1.done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_cycle: got done=%b, want 1", b1.done);
        end
        b1.start    = 1'b1;
        b1.blk_data = rand_blk();
        @(negedge clk);
        n_cmp++;
        if (b1.busy !== 1'b0 || b1.round_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done: got busy=%b valid=%b, want 0 0", b1.busy, b1.round_valid);
        end
        do_start(1, rand_blk());
        drain(0, -1, 1'b1);
    endtask

    task automatic test_rounds16();
        logic [511:0] blk;
        logic [31:0]  m;
        exp_t         e;
        int           guard;
        int           idx;
        blk = rand_blk();
        @(negedge clk);
        do_start(2, blk);
        guard = 0;
        while (sb2.size() > 0 && guard < 200) begin
            guard++;
            e = sb2[0];
            n_cmp++;
            if (b2.round_valid !== 1'b1 || b2.round_n !== e.n || b2.k_out !== e.k
                || b2.w_out !== e.w || b2.last !== e.last) begin
                n_fail++;
                $display("FAIL r16_round: got v=%b n=%0d k=%h w=%h last=%b, want v=1 n=%0d k=%h w=%h last=%b",
                         b2.round_valid, b2.round_n, b2.k_out, b2.w_out, b2.last, e.n, e.k, e.w, e.last);
            end
            idx = e.n;
            m   = blk[511 - 32*idx -: 32];
            n_cmp++;
            if (b2.w_out !== bswap(m)) begin
                n_fail++;
                $display("FAIL r16_bswap: got w=%h, want %h at round %0d", b2.w_out, bswap(m), idx);
            end
            b2.round_ready = 1'b1;
            void'(sb2.pop_front());
            @(negedge clk);
        end
        n_cmp++;
        if (b2.done !== 1'b1 || b2.round_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL r16_done: got done=%b valid=%b, want 1 0", b2.done, b2.round_valid);
        end
        @(negedge clk);
        b2.round_ready = 1'b0;
        n_cmp++;
        if (b2.done !== 1'b0 || b2.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL r16_idle: got done=%b busy=%b, want 0 0", b2.done, b2.busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        do_start(1, rand_blk());
        b1.round_ready = 1'b1;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (b1.round_n == 6'd30) break;
        end
        n_cmp++;
        if (b1.round_n !== 6'd30 || b1.round_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_round30: got n=%0d valid=%b, want 30 1", b1.round_n, b1.round_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({b1.busy, b1.round_valid, b1.round_n, b1.k_out, b1.w_out, b1.last, b1.done} !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b valid=%b n=%0d k=%h w=%h, want all 0",
                     b1.busy, b1.round_valid, b1.round_n, b1.k_out, b1.w_out);
        end
        @(negedge clk);
        rst = 1'b0;
        b1.round_ready = 1'b0;
        sb1.delete();
        @(negedge clk);
        do_start(1, rand_blk());
        drain(0, -1, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        b1.start = 1'b0; b1.blk_data = '0; b1.round_ready = 1'b0;
        b2.start = 1'b0; b2.blk_data = '0; b2.round_ready = 1'b0;
        test_reset();
        test_abc();
        test_backpressure();
        test_start();
        test_rounds16();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
